// File: rtl/mult_seq_pkg.sv
// Shared constants and types for the multi-select multiplier host driver.
package mult_seq_pkg;

  localparam int DW_DEF    = 8;
  localparam int OW_DEF    = 11;
  localparam int DEPTH_DEF = 4;

  // Multiplier output weights, one per frame phase.
  localparam int W1 = 1;
  localparam int W3 = 3;
  localparam int W7 = 7;
  localparam int W8 = 8;

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;
  typedef enum logic {UNSYNC, SYNC} state_t;

  // Weight carried by mul_out in a given phase.
  function automatic int weight(input phase_t p);
    case (p)
      P0:      return W1;
      P1:      return W3;
      P2:      return W7;
      default: return W8;
    endcase
  endfunction

endpackage

// File: rtl/mult_op_fifo.sv
// Operand FIFO: DEPTH x DW, registered count, read data is the head entry.
module mult_op_fifo
  import mult_seq_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;

  // Storage array, written on push only.
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rp];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mult_seq_host.sv
// Host driver for the 4-cycle multi-select multiplier: buffers operands,
// tracks the frame phase from mul_grant, captures and checks x1/x3/x7/x8.
module mult_seq_host
  import mult_seq_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int OW    = OW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] mul_d,
  input  logic          mul_grant,
  input  logic [OW-1:0] mul_out,
  output logic          res_valid,
  output logic [DW-1:0] res_op,
  output logic [OW-1:0] res_x1,
  output logic [OW-1:0] res_x3,
  output logic [OW-1:0] res_x7,
  output logic [OW-1:0] res_x8,
  output logic          res_err,
  output logic          sync_err
);

  state_t        st;
  phase_t        ph;        // phase of the previous cycle while SYNC
  phase_t        cur_ph;    // phase of the current cycle
  logic          cur_sync;  // current cycle belongs to a tracked frame
  logic          perr;      // grant out of phase in this cycle
  logic          busy;      // current frame carries a real operand
  logic          next_busy; // operand loaded for the following frame
  logic [DW-1:0] shadow, frm_op;
  logic [OW-1:0] cap_x1, cap_x3, cap_x7;
  logic          err_acc, mis;
  logic          push, pop, full, empty;
  logic [DW-1:0] fifo_q;
  logic [$clog2(DEPTH):0] fifo_cnt;

  function automatic logic [OW-1:0] scale(input logic [DW-1:0] op, input phase_t p);
    return OW'(op) * OW'(weight(p));
  endfunction

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = cur_sync && (cur_ph == P2) && !empty;
  assign mis      = (mul_out != scale(frm_op, cur_ph));

  mult_op_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_q),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  // Decide this cycle's phase: a grant always restarts at P0, a missing
  // grant where P0 was due drops back to UNSYNC.
  always_comb begin
    cur_ph   = P0;
    cur_sync = 1'b0;
    perr     = 1'b0;
    if (st == UNSYNC) begin
      cur_sync = mul_grant;
    end else if (mul_grant) begin
      cur_sync = 1'b1;
      perr     = (ph != P3);
    end else if (ph == P3) begin
      perr     = 1'b1;
    end else begin
      cur_sync = 1'b1;
      cur_ph   = phase_t'(ph + 2'd1);
    end
  end

  // Phase state, operand load at the P2 edge, capture/check and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= UNSYNC;
      ph        <= P0;
      busy      <= 1'b0;
      next_busy <= 1'b0;
      shadow    <= '0;
      frm_op    <= '0;
      mul_d     <= '0;
      cap_x1    <= '0;
      cap_x3    <= '0;
      cap_x7    <= '0;
      err_acc   <= 1'b0;
      res_valid <= 1'b0;
      res_op    <= '0;
      res_x1    <= '0;
      res_x3    <= '0;
      res_x7    <= '0;
      res_x8    <= '0;
      res_err   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      st        <= cur_sync ? SYNC : UNSYNC;
      ph        <= cur_ph;
      if (perr) begin
        // The interrupted frame and any operand already queued for the
        // next one are discarded; no result is produced for them.
        sync_err  <= 1'b1;
        busy      <= 1'b0;
        next_busy <= 1'b0;
      end else if (cur_sync) begin
        unique case (cur_ph)
          P0: begin
            cap_x1  <= mul_out;
            err_acc <= mis;
          end
          P1: begin
            cap_x3  <= mul_out;
            err_acc <= err_acc | mis;
          end
          P2: begin
            cap_x7    <= mul_out;
            err_acc   <= err_acc | mis;
            next_busy <= !empty;
            if (!empty) begin
              mul_d  <= fifo_q;
              shadow <= fifo_q;
            end
          end
          P3: begin
            if (busy) begin
              res_valid <= 1'b1;
              res_op    <= frm_op;
              res_x1    <= cap_x1;
              res_x3    <= cap_x3;
              res_x7    <= cap_x7;
              res_x8    <= mul_out;
              res_err   <= err_acc | mis;
            end
            busy   <= next_busy;
            frm_op <= shadow;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_host.sv
// Bench for mult_seq_host with a behavioural multiplier model and a
// scoreboard of expected result records.
module tb_mult_seq_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  mul_d;
  logic        mul_grant;
  logic [10:0] mul_out;
  logic        res_valid;
  logic [7:0]  res_op;
  logic [10:0] res_x1, res_x3, res_x7, res_x8;
  logic        res_err;
  logic        sync_err;

  typedef struct {
    logic [7:0]  op;
    bit          corrupt;
    logic [10:0] x1, x3, x7, x8;
    logic        err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  vec_t sbq[$];
  int   res_cyc[$];

  // model controls
  bit         gen_on      = 0;
  int         glitch_cnt  = 0;
  int         glitch_done = 0;
  bit         corrupt_on  = 0;
  logic [7:0] corrupt_op  = 0;
  logic [7:0] frame_d     = 0;
  int         m_ph        = 0;
  int         wt[4]       = '{1, 3, 7, 8};

  mult_seq_host dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mul_d(mul_d), .mul_grant(mul_grant),
    .mul_out(mul_out), .res_valid(res_valid), .res_op(res_op),
    .res_x1(res_x1), .res_x3(res_x3), .res_x7(res_x7), .res_x8(res_x8),
    .res_err(res_err), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op);
    vec_t v;
    v.op = op; v.corrupt = 0; v.err = 0;
    v.x1 = 11'(op * 1); v.x3 = 11'(op * 3); v.x7 = 11'(op * 7); v.x8 = 11'(op * 8);
    return v;
  endfunction

  // Multiplier model: grant every 4 cycles, operand latched at P0.
  initial begin
    mul_grant = 0;
    mul_out   = 0;
    forever begin
      @(posedge clk); #1;
      if (glitch_cnt != glitch_done) begin
        glitch_done = glitch_cnt;
        m_ph = 0;
      end else begin
        m_ph = (m_ph + 1) % 4;
      end
      if (gen_on) begin
        mul_grant = (m_ph == 0);
        if (m_ph == 0) frame_d = mul_d;
        mul_out = 11'(int'(frame_d) * wt[m_ph] +
                      ((corrupt_on && m_ph == 2 && frame_d == corrupt_op) ? 1 : 0));
      end else begin
        mul_grant = 0;
        mul_out   = 0;
      end
    end
  end

  // Result monitor: every pulse must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst && res_valid) begin
      res_cyc.push_back(cyc);
      chk("res_expected", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        vec_t e;
        e = sbq.pop_front();
        chk("res_op", res_op, e.op);
        chk("res_x1", res_x1, e.x1);
        chk("res_x3", res_x3, e.x3);
        chk("res_x7", res_x7, e.x7);
        chk("res_x8", res_x8, e.x8);
        chk("res_err", res_err, e.err);
      end
    end
  end

  task automatic push_op(input logic [7:0] op, input bit track, input vec_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_ready_timeout", in_ready, 1);
    in_valid = 1;
    in_data  = op;
    @(posedge clk);
    if (track) sbq.push_back(e);
    #1 in_valid = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sbq.size(), 0);
  endtask

  task automatic wait_frame(input logic [7:0] op);
    int n;
    n = 0;
    @(negedge clk);
    while (!(mul_grant && frame_d == op) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("frame_start_seen", int'(mul_grant && frame_d == op), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_mul_d"}, mul_d, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_op"}, res_op, 0);
    chk({tag, "_res_x1"}, res_x1, 0);
    chk({tag, "_res_x8"}, res_x8, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
  endtask

  vec_t vecs[6];
  vec_t dummy;
  int   base;

  initial begin
    vecs[0] = '{8'd5,   1'b0, 11'd5,   11'd15,  11'd35,   11'd40,   1'b0};
    vecs[1] = '{8'd255, 1'b0, 11'd255, 11'd765, 11'd1785, 11'd2040, 1'b0};
    vecs[2] = '{8'd0,   1'b0, 11'd0,   11'd0,   11'd0,    11'd0,    1'b0};
    vecs[3] = '{8'd128, 1'b0, 11'd128, 11'd384, 11'd896,  11'd1024, 1'b0};
    vecs[4] = '{8'd5,   1'b1, 11'd5,   11'd15,  11'd36,   11'd40,   1'b1};
    vecs[5] = '{8'd5,   1'b0, 11'd5,   11'd15,  11'd35,   11'd40,   1'b0};
    dummy   = mk(8'd0);

    rst = 0; in_valid = 0; in_data = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1;

    // Grants held low: the FIFO fills and the fifth push is refused.
    push_op(8'd10, 1, mk(8'd10));
    push_op(8'd20, 1, mk(8'd20));
    push_op(8'd30, 1, mk(8'd30));
    push_op(8'd40, 1, mk(8'd40));
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1; in_data = 8'd50;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("full_still_full", in_ready, 0);
    gen_on = 1;
    drain(120);
    chk("unsync_no_err", sync_err, 0);

    // Table-driven single operands, including one corrupted product.
    foreach (vecs[i]) begin
      corrupt_on = vecs[i].corrupt;
      corrupt_op = vecs[i].op;
      push_op(vecs[i].op, 1, vecs[i]);
      drain(60);
      corrupt_on = 0;
    end

    // Back-to-back operands: results exactly 4 cycles apart.
    base = res_cyc.size();
    push_op(8'd1, 1, mk(8'd1));
    push_op(8'd2, 1, mk(8'd2));
    push_op(8'd3, 1, mk(8'd3));
    drain(80);
    chk("b2b_count", res_cyc.size() - base, 3);
    if (res_cyc.size() - base == 3) begin
      chk("b2b_gap1", res_cyc[base+1] - res_cyc[base], 4);
      chk("b2b_gap2", res_cyc[base+2] - res_cyc[base+1], 4);
    end
    repeat (12) @(negedge clk);
    chk("idle_no_sync_err", sync_err, 0);

    // Grant one cycle into a busy frame: frame dropped, sync_err sticks.
    push_op(8'd9, 0, dummy);
    wait_frame(8'd9);
    glitch_cnt++;
    push_op(8'd6, 1, mk(8'd6));
    drain(80);
    chk("glitch_sync_err", sync_err, 1);

    // Reset in the middle of a busy frame.
    push_op(8'd7, 0, dummy);
    wait_frame(8'd7);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_reset_vals("midreset");
    rst = 1;
    repeat (16) @(negedge clk);
    chk("post_reset_sync_err", sync_err, 0);
    push_op(8'd3, 1, mk(8'd3));
    drain(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_host.md
# mult_seq_host

- Host-side driver for the 4-cycle multi-select multiplier interface.
- Accepts 8-bit operands from upstream through a valid/ready port and buffers them in a 4-deep FIFO.
- Presents one operand per multiplier frame on `mul_d`, tracks the frame phase from `mul_grant`, and collects the four products (x1, x3, x7, x8).
- Checks each product against locally computed values and emits one result record per operand.

## Interface
Parameters:
- DW, 8, operand width
- OW, 11, product width (holds 8×255 = 2040)
- DEPTH, 4, operand FIFO depth (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream operand valid
- in_data  in  DW  upstream operand
- in_ready  out  1  FIFO not full
- mul_d  out  DW  operand driven to multiplier
- mul_grant  in  1  multiplier frame marker; high in the cycle mul_out carries x1
- mul_out  in  OW  multiplier product stream
- res_valid  out  1  one-cycle result pulse
- res_op  out  DW  operand of this result
- res_x1, res_x3, res_x7, res_x8  out  OW each  captured products
- res_err  out  1  any captured product mismatched, valid with res_valid
- sync_err  out  1  sticky: mul_grant arrived out of phase

## Operation
Multiplier protocol (fixed):
- A frame is 4 cycles, phases P0–P3, with mul_grant=1 only in P0.
- mul_out carries d·1 in P0, d·3 in P1, d·7 in P2 and d·8 in P3.
- d is the mul_d value that was stable from the edge before P0 through the edge ending P2.

Phase tracking:
- States: UNSYNC, then SYNC with a 2-bit phase counter.
- UNSYNC → SYNC on the first mul_grant=1 (phase=0). In SYNC the phase increments mod 4 each cycle.
- If mul_grant=1 when phase≠3 at the preceding edge, or mul_grant=0 when P0 is expected:
  - set sync_err (sticky until reset);
  - drop the in-flight frame without a result and re-sync to the current grant, or go to UNSYNC if the grant is missing.

Operand load:
- At the edge ending P2 with the FIFO non-empty: pop the FIFO into mul_d, set next_busy=1, and store a shadow copy of the operand.
- If the FIFO is empty at that edge: mul_d holds its value and next_busy=0, so the next frame is idle and its products are ignored.
- In UNSYNC no pops occur.

Capture:
- In P0..P3 of a busy frame, register mul_out into res_x1/x3/x7/x8 respectively.
- Compare each product against shadow·{1,3,7,8}. The shifts/adds are computed in OW bits, no truncation for DW=8.
- Mismatches accumulate into res_err for the frame.

Result:
- res_valid=1 for exactly one cycle, the cycle after P3 of a busy frame.
- res_* and res_err are held until the next result.
- There is no backpressure on the result port.

FIFO:
- Push when in_valid && in_ready; in_ready = !full.
- A push in the same cycle as a pop while full is not possible: in_ready is low when full.
- A push while empty coinciding with the load edge is not bypassed; the operand is loaded at the next P2 edge.

## Timing
- Reset values: in_ready=1, mul_d=0, res_valid=0, res_op=0, res_x*=0, res_err=0, sync_err=0; state UNSYNC, FIFO empty.
- Reset mid-frame aborts everything with no result; the block re-syncs on the next grant.
- Latency, synced with an empty FIFO: operand accepted at edge T, loaded at the first P2-ending edge after T (1–4 cycles), result 5 cycles after the load edge.
- Sustained throughput is one operand per 4 cycles.
- All outputs are registered and there are no combinational in→out paths; in_ready derives from registered FIFO count.

## Structure
- Package mult_seq_pkg holds:
  - DW, OW, DEPTH defaults;
  - the phase encoding (P0..P3) and UNSYNC/SYNC state type;
  - weight constants W1=1, W3=3, W7=7, W8=8.
- One sub-module, mult_op_fifo: synchronous FIFO of DEPTH×DW with full/empty/count and the same clk/rst.
- Phase tracker, load logic and capture/check stay in mult_seq_host.

## Test plan
- Model multiplier emits grant every 4 cycles; push 5 → one result: op=5, x1=5, x3=15, x7=35, x8=40, res_err=0.
- Push 255 → x1=255, x3=765, x7=1785, x8=2040, res_err=0.
- Push 1, 2, 3 back-to-back → three res_valid pulses exactly 4 cycles apart, in order; no result for idle frames.
- Hold the model's grant low (UNSYNC) and push 4 operands → in_ready=0 after the 4th; a 5th push is refused. After grants start, the four results arrive in order.
- Model corrupts P2 product (36 instead of 35 for d=5) → res_err=1 on that result only.
- Grant at phase 1 → sync_err=1, in-flight frame dropped, next frame correct.
- Assert rst mid-frame → all outputs return to reset values and no res_valid occurs.
